hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipeline.
- Drives stall/flush enables of the F/D, D/E, E/M and M/W pipeline registers, and the ALU operand forwarding selects in E.
- Contains a memory-wait FSM with timeout detection and two performance counters.
- Sits beside the datapath and observes register addresses and control bits from D, E, M and W.

Parameters:
- ADDR_WIDTH, 5, register address width.
- TIMEOUT, 16, maximum consecutive memory-wait cycles before the error state; legal range 2..2^16.
- CNT_WIDTH, 32, performance counter width.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous reset, active-high
- Rs1D, Rs2D  in  ADDR_WIDTH  source registers in D
- Rs1E, Rs2E  in  ADDR_WIDTH  source registers in E
- RdE, RdM, RdW  in  ADDR_WIDTH  destination registers in E/M/W
- RegWriteM, RegWriteW  in  1  register-write enables in M/W
- ResultSrcE0  in  1  instruction in E is a load
- PCSrcE  in  1  branch/jump taken, resolved in E
- MemReqM  in  1  data-memory access active in M
- MemReadyM  in  1  data memory completes the access this cycle
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register
- FlushD, FlushE, FlushW  out  1  clear the corresponding pipeline register to a bubble
- ForwardAE, ForwardBE  out  2  operand select: 00 register file, 10 ALUResultM, 01 ResultW
- mem_timeout  out  1  sticky error flag
- stall_cycles  out  CNT_WIDTH  count of cycles with StallF=1
- flush_events  out  CNT_WIDTH  count of cycles with PCSrcE=1 that cause a flush

Behaviour:
- Reset (async, while rst=1):
  - state=RUN, wait_cnt=0, mem_timeout=0, both counters=0.
  - Outputs forced: all Stall*=0, FlushD=FlushE=FlushW=1, Forward*=00.
- Forwarding (combinational, per operand X in {A,B} using Rs1E/Rs2E):
  - 10 if RegWriteM and RdM!=0 and RdM==RsXE.
  - Else 01 if RegWriteW and RdW!=0 and RdW==RsXE.
  - Else 00. M has priority over W.
- Load-use: lwStall = ResultSrcE0 and RdE!=0 and (RdE==Rs1D or RdE==Rs2D).
- memStall = MemReqM and not MemReadyM, or state==ERROR.
- Output priority, highest first:
  1. memStall: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0. Pipe frozen; branch and load-use are deferred, since inputs are held.
  2. PCSrcE: FlushD=FlushE=1; StallF=StallD=0 even if lwStall, so the target fetch proceeds.
  3. lwStall: StallF=StallD=1, FlushE=1.
  4. Otherwise all 0.
- StallE/StallM/FlushW are 1 only in case 1.
- FSM, registered, transitions on the rising clk edge:
  - RUN: if memStall, go to WAIT with wait_cnt=1.
  - WAIT:
    - MemReadyM=1 → RUN, wait_cnt=0. Stall is released combinationally in the ready cycle, so the pipe advances at that edge.
    - MemReqM=0 → RUN (request withdrawn).
    - wait_cnt==TIMEOUT-1 and still not ready → ERROR, mem_timeout=1.
    - Otherwise wait_cnt+1.
  - ERROR: terminal. Whole pipe stalled, mem_timeout=1; exits only via rst.
- Wait latency: an access with ready on the Nth request cycle causes N-1 stall cycles. Exactly TIMEOUT-1 not-ready cycles followed by ready is legal; one more not-ready cycle enters ERROR.
- Counters:
  - stall_cycles increments on each edge where StallF=1, including memory and ERROR stalls.
  - flush_events increments on each edge where PCSrcE=1 and memStall=0.
  - Both wrap modulo 2^CNT_WIDTH with no saturation.
- Reset mid-WAIT or in ERROR returns to RUN immediately (async) and clears all registered state.

Test Plan:
- Forwarding:
  - RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 → ForwardAE=10.
  - Same with RegWriteM=0 → ForwardAE=01.
  - Rs2E=0 with RdM=0 → ForwardBE=00.
- Load-use: ResultSrcE0=1, RdE=7, Rs2D=7 → StallF=StallD=FlushE=1 for one cycle; stall_cycles 0→1.
  - Repeat with RdE=0 → no stall.
- Branch vs load-use: PCSrcE=1 with lwStall true → FlushD=FlushE=1, StallF=StallD=0; flush_events increments by 1.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles then 1 → StallF/D/E/M and FlushW=1 for 3 cycles, 0 in the ready cycle; state returns to RUN; stall_cycles=3.
- Timeout with TIMEOUT=4: MemReqM=1, MemReadyM=0 held → ERROR after the 4th edge, mem_timeout=1, all stalls stuck at 1 even after MemReadyM=1.
  - Assert rst mid-ERROR → mem_timeout=0, stalls 0, counters 0 without a clock edge.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: forwarding selects,
// load-use / branch / memory-wait stall and flush control, timeout FSM and perf counters.
//
// state  | meaning
// -------+----------------------------------------------------------
// RUN    | normal issue; memory not stalling the pipe
// WAIT   | data memory access outstanding, counting down to timeout
// ERROR  | memory timed out; whole pipe frozen until rst
module hazard_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int TIMEOUT    = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] Rs1D,
  input  logic [ADDR_WIDTH-1:0] Rs2D,
  input  logic [ADDR_WIDTH-1:0] Rs1E,
  input  logic [ADDR_WIDTH-1:0] Rs2E,
  input  logic [ADDR_WIDTH-1:0] RdE,
  input  logic [ADDR_WIDTH-1:0] RdM,
  input  logic [ADDR_WIDTH-1:0] RdW,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  ResultSrcE0,
  input  logic                  PCSrcE,
  input  logic                  MemReqM,
  input  logic                  MemReadyM,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushW,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  mem_timeout,
  output logic [CNT_WIDTH-1:0]  stall_cycles,
  output logic [CNT_WIDTH-1:0]  flush_events
);

  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // Remaining not-ready cycles allowed once WAIT is entered (wait count already 1).
  localparam logic [WW-1:0] WAIT_LOAD = WW'(TIMEOUT - 2);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_WAIT  = 2'd1,
    S_ERROR = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WW-1:0]        r_wait_left;
  logic [WW-1:0]        w_wait_left_nxt;
  logic                 r_mem_timeout;
  logic                 w_timeout_set;
  logic [CNT_WIDTH-1:0] r_stall_cycles;
  logic [CNT_WIDTH-1:0] r_flush_events;

  logic                 w_mem_stall;
  logic                 w_lw_stall;
  logic                 w_flush_evt;

  function automatic logic [1:0] fwd_sel(input logic [ADDR_WIDTH-1:0] rs);
    if (RegWriteM && (RdM != '0) && (RdM == rs))
      return 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign w_mem_stall = (MemReqM & ~MemReadyM) | (r_state == S_ERROR);
  assign w_lw_stall  = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign w_flush_evt = PCSrcE & ~w_mem_stall;

  always_comb begin
    w_state_nxt     = r_state;
    w_wait_left_nxt = r_wait_left;
    w_timeout_set   = 1'b0;
    StallF          = 1'b0;
    StallD          = 1'b0;
    StallE          = 1'b0;
    StallM          = 1'b0;
    FlushD          = 1'b0;
    FlushE          = 1'b0;
    FlushW          = 1'b0;
    ForwardAE       = 2'b00;
    ForwardBE       = 2'b00;

    case (r_state)
      S_RUN: begin
        if (w_mem_stall) begin
          w_state_nxt     = S_WAIT;
          w_wait_left_nxt = WAIT_LOAD;
        end
      end
      S_WAIT: begin
        if (MemReadyM || !MemReqM) begin
          w_state_nxt     = S_RUN;
          w_wait_left_nxt = '0;
        end else if (r_wait_left == '0) begin
          w_state_nxt   = S_ERROR;
          w_timeout_set = 1'b1;
        end else begin
          w_wait_left_nxt = r_wait_left - WW'(1);
        end
      end
      S_ERROR: begin
        w_state_nxt = S_ERROR;
      end
      default: begin
        w_state_nxt     = S_RUN;
        w_wait_left_nxt = '0;
      end
    endcase

    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else begin
      ForwardAE = fwd_sel(Rs1E);
      ForwardBE = fwd_sel(Rs2E);
      // Frozen pipe holds its inputs, so branch and load-use resolve after the wait.
      if (w_mem_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (w_lw_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_RUN;
      r_wait_left    <= '0;
      r_mem_timeout  <= 1'b0;
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_left <= w_wait_left_nxt;
      if (w_timeout_set)
        r_mem_timeout <= 1'b1;
      if (StallF)
        r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
      if (w_flush_evt)
        r_flush_events <= r_flush_events + CNT_WIDTH'(1);
    end
  end

  assign mem_timeout  = r_mem_timeout;
  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (TIMEOUT=4): forwarding, load-use, branch
// priority, memory wait, withdrawn request, timeout/ERROR and async reset.
module tb_hazard_ctrl;

  localparam int AW = 5;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic          RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM;
  logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          mem_timeout;
  logic [CW-1:0] stall_cycles, flush_events;

  typedef struct {
    string       tag;
    logic [11:0] ctl;
    logic [31:0] sc;
    logic [31:0] fe;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  hazard_ctrl #(.ADDR_WIDTH(AW), .TIMEOUT(4), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,ForwardAE,ForwardBE,mem_timeout}
  function automatic logic [11:0] mk(input logic sf, sd, se, sm, fd, fe, fw,
                                     input logic [1:0] fa, fb, input logic mt);
    return {sf, sd, se, sm, fd, fe, fw, fa, fb, mt};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
    RdE = '0; RdM = '0; RdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE0 = 1'b0;
    PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
  endtask

  // Push expectation for the inputs just driven, let them settle, then pop and compare.
  task automatic expect_now(input string tag, input logic [11:0] ctl,
                            input logic [31:0] sc, input logic [31:0] fe);
    exp_t e;
    sb.push_back('{tag, ctl, sc, fe});
    #2;
    e = sb.pop_front();
    check({e.tag, "/ctl"}, 32'({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                                ForwardAE, ForwardBE, mem_timeout}), 32'(e.ctl));
    check({e.tag, "/stall_cycles"}, stall_cycles, e.sc);
    check({e.tag, "/flush_events"}, flush_events, e.fe);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic mem_lw_branch();
    idle(); MemReqM = 1'b1; PCSrcE = 1'b1; ResultSrcE0 = 1'b1; RdE = 7; Rs1D = 7;
  endtask

  logic [11:0] c_zero, c_mem, c_err, c_rst;

  initial begin
    c_zero = mk(0,0,0,0,0,0,0,2'b00,2'b00,0);
    c_mem  = mk(1,1,1,1,0,0,1,2'b00,2'b00,0);
    c_err  = mk(1,1,1,1,0,0,1,2'b00,2'b00,1);
    c_rst  = mk(0,0,0,0,1,1,1,2'b00,2'b00,0);

    rst = 1'b1;
    idle(); RegWriteM = 1'b1; RdM = 5; Rs1E = 5;
    #1;
    expect_now("reset", c_rst, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    idle(); RegWriteM = 1'b1; RdM = 5; RegWriteW = 1'b1; RdW = 5; Rs1E = 5;
    expect_now("fwd_m_prio", mk(0,0,0,0,0,0,0,2'b10,2'b00,0), 0, 0);
    next_cycle();
    RegWriteM = 1'b0;
    expect_now("fwd_w", mk(0,0,0,0,0,0,0,2'b01,2'b00,0), 0, 0);
    next_cycle();
    idle(); RegWriteM = 1'b1; RegWriteW = 1'b1;
    expect_now("fwd_x0", c_zero, 0, 0);
    next_cycle();
    idle(); RegWriteM = 1'b1; RdM = 3; Rs1E = 3; RegWriteW = 1'b1; RdW = 9; Rs2E = 9;
    expect_now("fwd_both", mk(0,0,0,0,0,0,0,2'b10,2'b01,0), 0, 0);
    next_cycle();

    idle(); ResultSrcE0 = 1'b1; RdE = 7; Rs2D = 7;
    expect_now("load_use", mk(1,1,0,0,0,1,0,2'b00,2'b00,0), 0, 0);
    next_cycle();
    idle(); ResultSrcE0 = 1'b1;
    expect_now("load_use_x0", c_zero, 1, 0);
    next_cycle();
    idle(); ResultSrcE0 = 1'b1; RdE = 7; Rs1D = 7; PCSrcE = 1'b1;
    expect_now("branch_over_lw", mk(0,0,0,0,1,1,0,2'b00,2'b00,0), 1, 0);
    next_cycle();
    idle();
    expect_now("after_branch", c_zero, 1, 1);
    next_cycle();

    for (int i = 0; i < 3; i++) begin
      mem_lw_branch();
      expect_now($sformatf("mem_wait%0d", i), c_mem, 32'(1 + i), 1);
      next_cycle();
    end
    mem_lw_branch(); MemReadyM = 1'b1;
    expect_now("mem_ready", mk(0,0,0,0,1,1,0,2'b00,2'b00,0), 4, 1);
    next_cycle();
    idle(); MemReqM = 1'b1; MemReadyM = 1'b1;
    expect_now("mem_hit", c_zero, 4, 2);
    next_cycle();

    idle(); MemReqM = 1'b1;
    expect_now("withdraw_wait", c_mem, 4, 2);
    next_cycle();
    idle();
    expect_now("withdrawn", c_zero, 5, 2);
    next_cycle();

    for (int i = 0; i < 4; i++) begin
      idle(); MemReqM = 1'b1;
      expect_now($sformatf("to_wait%0d", i), c_mem, 32'(5 + i), 2);
      next_cycle();
    end
    idle(); MemReqM = 1'b1; MemReadyM = 1'b1;
    expect_now("error_ready", c_err, 9, 2);
    next_cycle();
    idle(); PCSrcE = 1'b1;
    expect_now("error_branch", c_err, 10, 2);
    next_cycle();

    rst = 1'b1;
    expect_now("reset_in_error", c_rst, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
